// File: rtl/issue_select_rr_part.sv
// Round-robin select-1 encoder over NUM_PARTS equal partitions of the issue-queue ready vector.
// Define RR_ISSUE_INTRA_RR_EN to add a per-partition round-robin pointer; otherwise lowest bit wins.
module issue_select_rr_part #(
  parameter int ENCODER_WIDTH = 32,
  parameter int NUM_PARTS     = 4,
  localparam int PART_W = ENCODER_WIDTH / NUM_PARTS,
  localparam int IDX_W  = $clog2(ENCODER_WIDTH),
  localparam int PTR_W  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [ENCODER_WIDTH-1:0] vector_i,
  output logic [ENCODER_WIDTH-1:0] grant_o,
  output logic                     grant_valid_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic [PTR_W-1:0]         part_ptr_o
);

  localparam int SUB_W = (PART_W > 1) ? $clog2(PART_W) : 1;

  if (ENCODER_WIDTH % NUM_PARTS != 0) begin : g_width_check
    $error("ENCODER_WIDTH must be a multiple of NUM_PARTS");
  end

  logic [PTR_W-1:0]  part_ptr_q, part_ptr_d;
  logic [PTR_W-1:0]  sel;
  logic [NUM_PARTS-1:0] part_nz;
  logic [SUB_W-1:0]  part_sub [NUM_PARTS];
  logic              advance;

`ifdef RR_ISSUE_INTRA_RR_EN
  logic [SUB_W-1:0]  intra_ptr_q [NUM_PARTS];
  logic [SUB_W-1:0]  intra_ptr_d [NUM_PARTS];
`endif

  // Per-partition pick: scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin : part_encode
    int b;
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    b        = 0;
    part_nz  = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      part_sub[p] = '0;
      part_nz[p]  = |vector_i[p*PART_W +: PART_W];
      for (int k = PART_W - 1; k >= 0; k--) begin
`ifdef RR_ISSUE_INTRA_RR_EN
        b = int'(intra_ptr_q[p]) + k;
        if (b >= PART_W) b = b - PART_W;
`else
        b = k;
`endif
        if (vector_i[p*PART_W + b]) part_sub[p] = SUB_W'(b);
      end
    end
  end

  always_comb begin : part_select
    int p;
    p   = 0;
    sel = '0;
    for (int k = NUM_PARTS - 1; k >= 0; k--) begin
      p = int'(part_ptr_q) + k;
      if (p >= NUM_PARTS) p = p - NUM_PARTS;
      if (part_nz[p]) sel = PTR_W'(p);
    end
  end

  always_comb begin : grant_gen
    grant_valid_o = |vector_i;
    grant_idx_o   = '0;
    grant_o       = '0;
    if (grant_valid_o) begin
      grant_idx_o = IDX_W'(int'(sel) * PART_W + int'(part_sub[sel]));
      grant_o     = ENCODER_WIDTH'(1) << grant_idx_o;
    end
  end

  assign advance = !flush_i && !stall_i && grant_valid_o;

  always_comb begin : ptr_next
    part_ptr_d = part_ptr_q;
    if (flush_i) begin
      part_ptr_d = '0;
    end else if (advance) begin
      part_ptr_d = (sel == PTR_W'(NUM_PARTS - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

`ifdef RR_ISSUE_INTRA_RR_EN
  always_comb begin : intra_next
    for (int p = 0; p < NUM_PARTS; p++) begin
      intra_ptr_d[p] = intra_ptr_q[p];
      if (flush_i) begin
        intra_ptr_d[p] = '0;
      end else if (advance && sel == PTR_W'(p)) begin
        intra_ptr_d[p] = (part_sub[p] == SUB_W'(PART_W - 1)) ? '0 : part_sub[p] + SUB_W'(1);
      end
    end
  end

  // NOTE: the intra pointers are a handful of flops, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PARTS; p++) intra_ptr_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PARTS; p++) intra_ptr_q[p] <= intra_ptr_d[p];
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) part_ptr_q <= '0;
    else       part_ptr_q <= part_ptr_d;
  end

  assign part_ptr_o = part_ptr_q;

endmodule

// File: tb/tb_issue_select_rr_part.sv
// Directed bench for issue_select_rr_part at ENCODER_WIDTH=16, NUM_PARTS=4.
// Expected values are hand-derived; the intra-partition variant is selected by RR_ISSUE_INTRA_RR_EN.
module tb_issue_select_rr_part;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic [15:0] vector_i;
  logic [15:0] grant_o;
  logic        grant_valid_o;
  logic [3:0]  grant_idx_o;
  logic [1:0]  part_ptr_o;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef RR_ISSUE_INTRA_RR_EN
  localparam logic [15:0] T2_LAST = 16'h0002;
  localparam logic [15:0] T6_EXP [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};
`else
  localparam logic [15:0] T2_LAST = 16'h0001;
  localparam logic [15:0] T6_EXP [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
`endif

  issue_select_rr_part #(
    .ENCODER_WIDTH (16),
    .NUM_PARTS     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .vector_i      (vector_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .grant_idx_o   (grant_idx_o),
    .part_ptr_o    (part_ptr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] t2_grant [5];
    logic [3:0]  t2_idx   [5];
    logic [1:0]  t2_ptr   [5];
    t2_grant = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, T2_LAST};
    t2_idx   = '{4'd0, 4'd4, 4'd8, 4'd12, (T2_LAST == 16'h0002) ? 4'd1 : 4'd0};
    t2_ptr   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset    = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    vector_i = '0;
    #12;
    reset = 1'b0;
    #1;

    // 1. reset state
    check("rst_grant", grant_o, 16'h0000);
    check("rst_valid", grant_valid_o, 1'b0);
    check("rst_idx",   grant_idx_o, 4'd0);
    check("rst_ptr",   part_ptr_o, 2'd0);

    // 2. full vector rotates across partitions
    vector_i = 16'hFFFF;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), grant_o, t2_grant[i]);
      check($sformatf("rr_idx%0d", i),   grant_idx_o, t2_idx[i]);
      check($sformatf("rr_ptr%0d", i),   part_ptr_o, t2_ptr[i]);
      check($sformatf("rr_valid%0d", i), grant_valid_o, 1'b1);
      step();
    end
    check("rr_ptr_after", part_ptr_o, 2'd1);

    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_ptr", part_ptr_o, 2'd0);

    // 3. wrap from ptr=3 back to partition 0
    vector_i = 16'h0100;
    #1;
    check("p2_only_grant", grant_o, 16'h0100);
    step();
    check("ptr_at3", part_ptr_o, 2'd3);
    vector_i = 16'h0003;
    #1;
    check("wrap_grant", grant_o, 16'h0001);
    check("wrap_idx",   grant_idx_o, 4'd0);
    step();
    check("wrap_ptr_next", part_ptr_o, 2'd1);

    // 4. stall holds state
    flush_i = 1'b1;
    step();
    flush_i  = 1'b0;
    stall_i  = 1'b1;
    vector_i = 16'hFFFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_grant%0d", i), grant_o, 16'h0001);
      check($sformatf("stall_ptr%0d", i),   part_ptr_o, 2'd0);
      step();
    end
    check("stall_ptr_end", part_ptr_o, 2'd0);
    stall_i = 1'b0;
    #1;
    check("release_grant", grant_o, 16'h0001);
    step();
    check("release_ptr", part_ptr_o, 2'd1);

    // 5. flush beats stall, then async reset mid-run
    step();
    check("ptr_at2", part_ptr_o, 2'd2);
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    check("flush_over_stall", part_ptr_o, 2'd0);
    step();
    check("pre_reset_ptr", part_ptr_o, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ptr",   part_ptr_o, 2'd0);
    check("async_rst_grant", grant_o, 16'h0001);
    #1;
    reset = 1'b0;

    // 6. lower nibble only: intra behaviour
    vector_i = 16'h000F;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("intra_grant%0d", i), grant_o, T6_EXP[i]);
      step();
    end

    // Boundaries: empty vector holds, top bit reachable
    vector_i = 16'h0000;
    #1;
    check("empty_grant", grant_o, 16'h0000);
    check("empty_valid", grant_valid_o, 1'b0);
    check("empty_idx",   grant_idx_o, 4'd0);
    step();
    check("empty_hold_ptr", part_ptr_o, 2'd1);
    vector_i = 16'h8000;
    #1;
    check("top_grant", grant_o, 16'h8000);
    check("top_idx",   grant_idx_o, 4'd15);
    step();
    check("top_ptr_wrap", part_ptr_o, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
